// File: rtl/dff_delay_line.sv
// WIDTH-bit, DEPTH-stage registered delay line with per-stage valid,
// flush, stall, selectable tap and registered occupancy count.
module dff_delay_line #(
    parameter int              WIDTH    = 8,
    parameter int              DEPTH    = 4,
    parameter bit              NEG_EDGE = 1'b1,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int             TAP_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int             OCC_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    input  logic [TAP_W-1:0] tap_sel,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [WIDTH-1:0] tap_q,
    output logic             tap_valid,
    output logic [OCC_W-1:0] occupancy
);

    logic [WIDTH-1:0] stage   [DEPTH];
    logic [WIDTH-1:0] stage_n [DEPTH];
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] v_n;
    logic [OCC_W-1:0] cnt;
    logic             aclk;

    // Falling-edge variant is a plain clock inversion feeding one register bank
    assign aclk = NEG_EDGE ? ~clk : clk;

    always_comb begin
        stage_n = stage;
        v_n     = v;
        if (flush) begin
            v_n = '0;
        end else if (en) begin
            stage_n[0] = d;
            v_n[0]     = d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                stage_n[i] = stage[i-1];
                v_n[i]     = v[i-1];
            end
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + OCC_W'(v_n[i]);
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RST_VAL;
            end
            v         <= '0;
            occupancy <= '0;
        end else begin
            stage     <= stage_n;
            v         <= v_n;
            occupancy <= cnt;
        end
    end

    assign q       = stage[DEPTH-1];
    assign q_valid = v[DEPTH-1];

    // Out-of-range selects fall through to the reset value
    always_comb begin
        tap_q     = RST_VAL;
        tap_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == TAP_W'(i)) begin
                tap_q     = stage[i];
                tap_valid = v[i];
            end
        end
    end

endmodule

// File: tb/tb_dff_delay_line.sv
// Bench for dff_delay_line: falling/rising-edge DEPTH=4 lines plus a DEPTH=3
// line, checked against a queue model of the stage contents.
module tb_dff_delay_line;

    localparam logic [7:0] R = 8'hA5;

    logic       clk = 1'b0;
    logic       rst0 = 1'b0, rst1 = 1'b0;
    logic       en = 1'b0, flush = 1'b0, d_valid = 1'b0;
    logic [7:0] d = 8'h00;
    logic [1:0] tap_sel = 2'd0;

    logic [7:0] q0, q1, q2, t0, t1, t2;
    logic       qv0, qv1, qv2, tv0, tv1, tv2;
    logic [2:0] o0, o1;
    logic [1:0] o2;

    always #5 clk = ~clk;

    dff_delay_line #(.WIDTH(8), .DEPTH(4), .NEG_EDGE(1'b1), .RST_VAL(R)) u0 (
        .clk(clk), .rst(rst0), .en(en), .flush(flush), .d(d),
        .d_valid(d_valid), .tap_sel(tap_sel), .q(q0), .q_valid(qv0),
        .tap_q(t0), .tap_valid(tv0), .occupancy(o0));

    dff_delay_line #(.WIDTH(8), .DEPTH(4), .NEG_EDGE(1'b0), .RST_VAL(R)) u1 (
        .clk(clk), .rst(rst1), .en(en), .flush(flush), .d(d),
        .d_valid(d_valid), .tap_sel(tap_sel), .q(q1), .q_valid(qv1),
        .tap_q(t1), .tap_valid(tv1), .occupancy(o1));

    dff_delay_line #(.WIDTH(8), .DEPTH(3), .NEG_EDGE(1'b1), .RST_VAL(R)) u2 (
        .clk(clk), .rst(rst0), .en(en), .flush(flush), .d(d),
        .d_valid(d_valid), .tap_sel(tap_sel), .q(q2), .q_valid(qv2),
        .tap_q(t2), .tap_valid(tv2), .occupancy(o2));

    bit         pos_mode = 1'b0;
    logic [7:0] qx, tx;
    logic       qvx, tvx;
    logic [2:0] ox;

    assign qx  = pos_mode ? q1  : q0;
    assign qvx = pos_mode ? qv1 : qv0;
    assign ox  = pos_mode ? o1  : o0;
    assign tx  = pos_mode ? t1  : t0;
    assign tvx = pos_mode ? tv1 : tv0;

    // sq holds stages 0..2 (oldest first = stage 2); last is stage 3
    logic [8:0] sq[$];
    logic [8:0] last;
    int         total = 0;
    int         bad = 0;

    function automatic logic [2:0] m_occ();
        int c = int'(last[8]);
        foreach (sq[i]) c += int'(sq[i][8]);
        return 3'(c);
    endfunction

    function automatic logic [8:0] m_stage(input int i);
        return (i == 3) ? last : sq[2-i];
    endfunction

    task automatic model_reset();
        sq.delete();
        repeat (3) sq.push_back({1'b0, R});
        last = {1'b0, R};
    endtask

    task automatic edge_wait();
        if (pos_mode) @(posedge clk);
        else @(negedge clk);
        #1;
    endtask

    task automatic step(input logic e, input logic fl,
                        input logic dv, input logic [7:0] dd);
        en = e; flush = fl; d_valid = dv; d = dd;
        edge_wait();
        if (fl) begin
            foreach (sq[i]) sq[i][8] = 1'b0;
            last[8] = 1'b0;
        end else if (e) begin
            sq.push_back({dv, dd});
            last = sq.pop_front();
        end
    endtask

    task automatic reset_step(input logic fl);
        if (pos_mode) rst1 = 1'b1;
        else rst0 = 1'b1;
        en = 1'b1; flush = fl; d_valid = 1'b1; d = 8'h77;
        edge_wait();
        rst0 = 1'b0; rst1 = 1'b0; flush = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        pos_mode = 1'b0;
        reset_step(1'b0);
        total++;
        if ({qv0, q0, o0} !== {1'b0, R, 3'd0}) begin
            bad++;
            $display("FAIL reset_out got %b/%h/%0d want 0/%h/0", qv0, q0, o0, R);
        end
        tap_sel = 2'd2; #1;
        total++;
        if ({tv0, t0} !== {1'b0, R}) begin
            bad++;
            $display("FAIL reset_tap got %b/%h want 0/%h", tv0, t0, R);
        end
        total++;
        if ({qv2, q2, o2} !== {1'b0, R, 2'd0}) begin
            bad++;
            $display("FAIL reset_d3 got %b/%h/%0d want 0/%h/0", qv2, q2, o2, R);
        end
    endtask

    task automatic test_stream();
        reset_step(1'b0);
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'(i));
            total++;
            if ({qvx, qx, ox} !== {last[8], last[7:0], m_occ()}) begin
                bad++;
                $display("FAIL stream pos=%0d edge %0d got %b/%h/%0d want %b/%h/%0d",
                         pos_mode, i, qvx, qx, ox, last[8], last[7:0], m_occ());
            end
        end
        total++;
        if (qx !== 8'h03) begin
            bad++;
            $display("FAIL stream_end pos=%0d got %h want 03", pos_mode, qx);
        end
    endtask

    task automatic test_glitch();
        if (pos_mode) rst1 = 1'b1;
        else rst0 = 1'b1;
        #3;
        rst0 = 1'b0; rst1 = 1'b0;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        total++;
        if ({qvx, qx, ox} !== {last[8], last[7:0], m_occ()}) begin
            bad++;
            $display("FAIL glitch pos=%0d got %b/%h/%0d want %b/%h/%0d",
                     pos_mode, qvx, qx, ox, last[8], last[7:0], m_occ());
        end
    endtask

    task automatic test_edge_select();
        pos_mode = 1'b1;
        test_stream();
        test_glitch();
        pos_mode = 1'b0;
    endtask

    task automatic test_midreset();
        reset_step(1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h11);
        step(1'b1, 1'b0, 1'b1, 8'h22);
        reset_step(1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'(8'h88 + i));
            total++;
            if ({qvx, qx, ox} !== {last[8], last[7:0], m_occ()}) begin
                bad++;
                $display("FAIL midreset edge %0d got %b/%h/%0d want %b/%h/%0d",
                         i, qvx, qx, ox, last[8], last[7:0], m_occ());
            end
        end
    endtask

    task automatic test_stall_tap();
        reset_step(1'b0);
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b1, 8'(i * 16));
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'hEE);
            total++;
            if ({qvx, qx, ox} !== {1'b1, 8'h10, 3'd4}) begin
                bad++;
                $display("FAIL stall cycle %0d got %b/%h/%0d want 1/10/4",
                         i, qvx, qx, ox);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tap_sel = 2'(i); #1;
            total++;
            if ({tvx, tx} !== m_stage(i)) begin
                bad++;
                $display("FAIL tap sel %0d got %b/%h want %b/%h",
                         i, tvx, tx, m_stage(i)[8], m_stage(i)[7:0]);
            end
        end
        tap_sel = 2'd3; #1;
        total++;
        if ({tv2, t2} !== {1'b0, R}) begin
            bad++;
            $display("FAIL tap_oor got %b/%h want 0/%h", tv2, t2, R);
        end
        tap_sel = 2'd2; #1;
        total++;
        if ({tv2, t2} !== {1'b1, 8'h20}) begin
            bad++;
            $display("FAIL tap_d3_last got %b/%h want 1/20", tv2, t2);
        end
    endtask

    task automatic test_flush();
        step(1'b1, 1'b1, 1'b1, 8'hFF);
        total++;
        if ({qvx, qx, ox} !== {1'b0, 8'h10, 3'd0}) begin
            bad++;
            $display("FAIL flush_out got %b/%h/%0d want 0/10/0", qvx, qx, ox);
        end
        for (int i = 0; i < 4; i++) begin
            tap_sel = 2'(i); #1;
            total++;
            if ({tvx, tx} !== m_stage(i)) begin
                bad++;
                $display("FAIL flush_tap sel %0d got %b/%h want %b/%h",
                         i, tvx, tx, m_stage(i)[8], m_stage(i)[7:0]);
            end
        end
        reset_step(1'b1);
        for (int i = 0; i < 4; i++) begin
            tap_sel = 2'(i); #1;
            total++;
            if ({tvx, tx} !== {1'b0, R}) begin
                bad++;
                $display("FAIL rst_flush_tap sel %0d got %b/%h want 0/%h",
                         i, tvx, tx, R);
            end
        end
    endtask

    task automatic test_bubbles();
        reset_step(1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, ~i[0], 8'(i + 1));
            total++;
            if ({qvx, qx, ox} !== {last[8], last[7:0], m_occ()}) begin
                bad++;
                $display("FAIL bubble edge %0d got %b/%h/%0d want %b/%h/%0d",
                         i, qvx, qx, ox, last[8], last[7:0], m_occ());
            end
        end
        total++;
        if (ox !== 3'd2) begin
            bad++;
            $display("FAIL bubble_occ got %0d want 2", ox);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_glitch();
        test_edge_select();
        test_midreset();
        test_stall_tap();
        test_flush();
        test_bubbles();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
